// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// Used by dm_port_arbiter, its interface and the optional perf counters.
package dm_arb_pkg;

    localparam int DM_ADDR_W = 32;
    localparam int DM_DATA_W = 32;
    localparam int STARVE_W  = 4;
    localparam int CNT_W     = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DBG = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } gnt_src_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// CPU, debug and memory-side signal bundle of the data-memory arbiter.
// slave: the arbiter itself; master: the surrounding requesters and memory.
interface dm_port_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_ack_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_rdata_o, dbg_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_rdata_o, dbg_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );

endinterface

// File: rtl/dm_arb_perf_cnt.sv
// Wrapping stall-cycle and debug-grant counters for the arbiter.
// Instantiated only when DM_ARB_PERF_CNT_EN is defined.
module dm_arb_perf_cnt
    import dm_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             dbg_grant,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] dbg_grant_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt     <= '0;
            dbg_grant_cnt <= '0;
        end else begin
            if (stall)     stall_cnt     <= stall_cnt + 1'b1;
            if (dbg_grant) dbg_grant_cnt <= dbg_grant_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between MEM stage and debug port.
// Optional perf counters: define DM_ARB_PERF_CNT_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = DM_ADDR_W,
    parameter int DATA_W     = DM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dm_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] dbg_grant_cnt_o
);

    arb_state_e          state_q, state_d;
    gnt_src_e            gnt;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starve_full;
    logic                grant;

    assign starve_full = (starve_q == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        gnt      = GNT_CPU;
        grant    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.dbg_req_i) starve_d = '0;
                if (bus.dbg_req_i &&
                    (!bus.cpu_req_i || starve_full)) begin
                    gnt      = GNT_DBG;
                    grant    = 1'b1;
                    state_d  = BUSY_DBG;
                    starve_d = '0;
                end else if (bus.cpu_req_i) begin
                    grant   = 1'b1;
                    state_d = BUSY_CPU;
                    // debug port is losing this round
                    if (bus.dbg_req_i && !starve_full)
                        starve_d = starve_q + 1'b1;
                end
                if (grant) begin
                    req_d = 1'b1;
                    if (gnt == GNT_DBG) begin
                        we_d    = bus.dbg_we_i;
                        addr_d  = bus.dbg_addr_i;
                        wdata_d = bus.dbg_wdata_i;
                    end else begin
                        we_d    = bus.cpu_we_i;
                        addr_d  = bus.cpu_addr_i;
                        wdata_d = bus.cpu_wdata_i;
                    end
                end
            end
            BUSY_CPU, BUSY_DBG: begin
                if (bus.mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    assign bus.cpu_rdata_o = bus.mem_rdata_i;
    assign bus.dbg_rdata_o = bus.mem_rdata_i;
    assign bus.dbg_ack_o   = (state_q == BUSY_DBG) && bus.mem_ack_i;
    assign bus.cpu_stall_o = bus.cpu_req_i &&
        !((state_q == BUSY_CPU) && bus.mem_ack_i);

`ifdef DM_ARB_PERF_CNT_EN
    logic dbg_grant;

    assign dbg_grant = grant && (gnt == GNT_DBG);

    dm_arb_perf_cnt u_perf (
        .clk           (clk_i),
        .rst           (rst_i),
        .stall         (bus.cpu_stall_o),
        .dbg_grant     (dbg_grant),
        .stall_cnt     (stall_cnt_o),
        .dbg_grant_cnt (dbg_grant_cnt_o)
    );
`else
    assign stall_cnt_o     = '0;
    assign dbg_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small wait-state memory model.
// Build with DM_ARB_PERF_CNT_EN to exercise the perf counters.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cnt;
    logic [31:0] dbg_grant_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [16];
    int unsigned mem_wait = 0;
    int unsigned wcnt = 0;

    dm_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dm_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus.slave),
        .stall_cnt_o     (stall_cnt),
        .dbg_grant_cnt_o (dbg_grant_cnt)
    );

    always #5 clk = ~clk;

    // memory: ack after mem_wait extra cycles, write on the ack edge
    always_comb bus.mem_ack_i = bus.mem_req_o && (wcnt == mem_wait);
    always_comb bus.mem_rdata_i = mem[bus.mem_addr_o[5:2]];

    always @(posedge clk) begin
        if (bus.mem_req_o && !bus.mem_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.mem_req_o && bus.mem_ack_i && bus.mem_we_o)
            mem[bus.mem_addr_o[5:2]] <= bus.mem_wdata_o;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      tag, got, exp);
    endtask

    task automatic cpu_access(input  logic        we,
                              input  logic [31:0] addr,
                              input  logic [31:0] wdata,
                              output int          stalls,
                              output logic [31:0] rdata,
                              output logic        stable,
                              output logic        ok);
        stalls = 0;
        rdata  = '0;
        stable = 1'b1;
        ok     = 1'b0;
        @(posedge clk); #1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.mem_req_o &&
                (bus.mem_addr_o !== addr ||
                 bus.mem_wdata_o !== wdata ||
                 bus.mem_we_o !== we))
                stable = 1'b0;
            if (bus.cpu_stall_o) stalls++;
            else begin
                ok    = 1'b1;
                rdata = bus.cpu_rdata_o;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
    endtask

    task automatic dbg_access(input  logic        we,
                              input  logic [31:0] addr,
                              input  logic [31:0] wdata,
                              output logic [31:0] rdata,
                              output logic        ok);
        rdata = '0;
        ok    = 1'b0;
        @(posedge clk); #1;
        bus.dbg_req_i   = 1'b1;
        bus.dbg_we_i    = we;
        bus.dbg_addr_i  = addr;
        bus.dbg_wdata_i = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.dbg_ack_o) begin
                ok    = 1'b1;
                rdata = bus.dbg_rdata_o;
            end
        end
        @(posedge clk); #1;
        bus.dbg_req_i = 1'b0;
    endtask

    initial begin
        int          stalls;
        int          ncpu;
        logic [31:0] rd;
        logic [31:0] starve_at;
        logic [31:0] starve_pk;
        logic        stable;
        logic        ok;
        logic        got;

        rst             = 1'b1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        bus.dbg_req_i   = 1'b0;
        bus.dbg_we_i    = 1'b0;
        bus.dbg_addr_i  = '0;
        bus.dbg_wdata_i = '0;

        // reset state
        @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req_o), 0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 0);
        chk("rst_dbg_ack", 32'(bus.dbg_ack_o), 0);
        chk("rst_stall_req1", 32'(bus.cpu_stall_o), 1);
        bus.cpu_req_i = 1'b0;
        #1;
        chk("rst_stall_req0", 32'(bus.cpu_stall_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // preload 0x10 <- 42 through the debug port
        dbg_access(1'b1, 32'h10, 32'h2A, rd, ok);
        chk("preload_ack", 32'(ok), 1);

        // CPU load, zero-wait
        cpu_access(1'b0, 32'h10, 32'h0, stalls, rd, stable, ok);
        chk("ld_done", 32'(ok), 1);
        chk("ld_stalls", stalls, 1);
        chk("ld_rdata", rd, 32'h2A);

        // CPU store with 3 wait cycles
        mem_wait = 3;
        cpu_access(1'b1, 32'h8, 32'h7, stalls, rd, stable, ok);
        chk("st_done", 32'(ok), 1);
        chk("st_stalls", stalls, 4);
        chk("st_stable", 32'(stable), 1);
        chk("st_mem", mem[2], 32'h7);
        mem_wait = 0;

        // starvation: continuous CPU loads, debug write held
        @(posedge clk); #1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = 32'h10;
        bus.cpu_wdata_i = 32'h0;
        bus.dbg_req_i   = 1'b1;
        bus.dbg_we_i    = 1'b1;
        bus.dbg_addr_i  = 32'h20;
        bus.dbg_wdata_i = 32'h55;
        ncpu      = 0;
        got       = 1'b0;
        starve_at = '1;
        starve_pk = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (32'(dut.starve_q) > starve_pk)
                starve_pk = 32'(dut.starve_q);
            if (bus.dbg_ack_o) begin
                got       = 1'b1;
                starve_at = 32'(dut.starve_q);
            end else if (bus.cpu_req_i && !bus.cpu_stall_o) begin
                ncpu++;
            end
        end
        chk("stv_dbg_ack", 32'(got), 1);
        chk("stv_cpu_grants", ncpu, 4);
        chk("stv_peak", starve_pk, 4);
        chk("stv_cleared", starve_at, 0);
        @(posedge clk); #1;
        bus.dbg_req_i = 1'b0;
        @(negedge clk);
        chk("stv_ack_pulse", 32'(bus.dbg_ack_o), 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (i > 0) @(negedge clk);
            if (!bus.cpu_stall_o) got = 1'b1;
        end
        chk("stv_cpu_resume", 32'(got), 1);
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
        chk("stv_dbg_mem", mem[8], 32'h55);
        repeat (2) @(posedge clk);
        #1;

        // simultaneous first requests: CPU first
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h10;
        bus.dbg_req_i  = 1'b1;
        bus.dbg_we_i   = 1'b0;
        bus.dbg_addr_i = 32'h8;
        @(negedge clk);
        chk("sim_c0_stall", 32'(bus.cpu_stall_o), 1);
        @(negedge clk);
        chk("sim_cpu_addr", bus.mem_addr_o, 32'h10);
        chk("sim_cpu_stall", 32'(bus.cpu_stall_o), 0);
        chk("sim_cpu_rdata", bus.cpu_rdata_o, 32'h2A);
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
        @(negedge clk);
        chk("sim_dbg_wait", 32'(bus.dbg_ack_o), 0);
        @(negedge clk);
        chk("sim_dbg_ack", 32'(bus.dbg_ack_o), 1);
        chk("sim_dbg_rdata", bus.dbg_rdata_o, 32'h7);
        @(posedge clk); #1;
        bus.dbg_req_i = 1'b0;

        // reset while the debug access waits on memory
        mem_wait = 100;
        @(posedge clk); #1;
        bus.dbg_req_i  = 1'b1;
        bus.dbg_we_i   = 1'b0;
        bus.dbg_addr_i = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_busy", 32'(bus.mem_req_o), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req_drop", 32'(bus.mem_req_o), 0);
        chk("mid_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_no_ack", 32'(bus.dbg_ack_o), 0);
        bus.dbg_req_i = 1'b0;
        mem_wait = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_access(1'b0, 32'h10, 32'h0, stalls, rd, stable, ok);
        chk("post_rst_done", 32'(ok), 1);
        chk("post_rst_stalls", stalls, 1);
        chk("post_rst_rdata", rd, 32'h2A);

        // perf counters from a fresh reset
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dbg_access(1'b1, 32'h30 + 32'(4 * i), 32'(i + 1), rd, ok);
            chk("perf_dbg_ack", 32'(ok), 1);
        end
        for (int i = 0; i < 5; i++)
            cpu_access(1'b0, 32'h10, 32'h0, stalls, rd, stable, ok);
        @(negedge clk);
`ifdef DM_ARB_PERF_CNT_EN
        chk("perf_dbg_grants", dbg_grant_cnt, 3);
        chk("perf_stalls", stall_cnt, 5);
`else
        chk("perf_dbg_grants", dbg_grant_cnt, 0);
        chk("perf_stalls", stall_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
